render_sequencer: RTL and testbench

RENDER_SEQUENCER -- requirements
Module: render_sequencer

---
 rtl/gpu_pkg.sv | 29 ++
 rtl/clear_engine.sv | 65 ++++++
 rtl/render_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_render_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpu_pkg
//  Description : Shared types and constants for the render sequencer slice:
//                sequencer state enum, buffer geometry and Z-buffer far value.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpu_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int FB_WORDS = SCREEN_W * SCREEN_H;   // 76800 words

  // 17 bits covers 0..76799 without wrap
  localparam int ADDR_W = 17;

  localparam logic [7:0] ZBUF_FAR = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_ACCEPT    = 3'd2,
    ST_DISPATCH  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_SWAP      = 3'd5
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/clear_engine.sv
`default_nettype none
// ============================================================================
//  Module      : clear_engine
//  Description : Sweeps the frame and Z buffers once, one word per cycle,
//                addresses 0..NUM_WORDS-1 ascending. The fill color is
//                captured on the start pulse; Z is filled with ZBUF_FAR.
//  Ports       : clk, rst_n        clock / async active-low reset
//                start             begin a sweep (ignored while running)
//                color             fill color, sampled with start
//                done              high during the last write of the sweep
//                we                write strobe for both buffers
//                addr              current word address
//                fb_data, zb_data  write data for frame / Z buffer
//  Revision    : 1.0 - initial release
// ============================================================================
module clear_engine
  import gpu_pkg::*;
#(
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        color,
  output logic              done,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        fb_data,
  output logic [7:0]        zb_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  logic              running;
  logic [ADDR_W-1:0] addr_cnt;
  logic [7:0]        color_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running  <= 1'b0;
      addr_cnt <= '0;
      color_q  <= '0;
    end else if (start && !running) begin
      running  <= 1'b1;
      addr_cnt <= '0;
      color_q  <= color;
    end else if (running) begin
      // Stop on the terminal word; the counter is parked at 0, never wraps
      if (addr_cnt == LAST_ADDR) begin
        running  <= 1'b0;
        addr_cnt <= '0;
      end else begin
        addr_cnt <= addr_cnt + 1'b1;
      end
    end
  end

  assign done    = running && (addr_cnt == LAST_ADDR);
  assign we      = running;
  assign addr    = addr_cnt;
  assign fb_data = color_q;
  assign zb_data = ZBUF_FAR;

endmodule
`default_nettype wire

// File: rtl/render_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : render_sequencer
//  Description : Frame-level sequencer for a triangle rasterizer. Clears the
//                frame/Z buffers at frame start, hands triangles to the
//                rasterizer one at a time, and swaps the front buffer when
//                the frame is closed.
//  Ports       : clk, rst_n                 clock / async active-low reset
//                frame_start, clear_color   open a frame with a clear color
//                tri_valid / tri_ready      triangle handshake
//                frame_end                  close frame after last triangle
//                frame_done, buf_sel        swap pulse / front-buffer select
//                busy, tri_count            status
//                rast_start / rast_done     rasterizer control
//                rast_fb_*, rast_zb_*       rasterizer memory requests
//                fb_*, zb_*                 frame / Z buffer BRAM ports
//                timeout_err                sticky watchdog flag
//  Config      : define RASTER_TIMEOUT_EN to build the rasterizer watchdog
//                (limit TIMEOUT_CYCLES); without it timeout_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module render_sequencer #(
  parameter int FB_WORDS       = gpu_pkg::FB_WORDS,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [7:0]                 clear_color,
  input  logic                       tri_valid,
  output logic                       tri_ready,
  input  logic                       frame_end,
  output logic                       frame_done,
  output logic                       buf_sel,
  output logic                       busy,
  output logic [15:0]                tri_count,
  output logic                       rast_start,
  input  logic                       rast_done,
  input  logic                       rast_fb_we,
  input  logic [gpu_pkg::ADDR_W-1:0] rast_fb_addr,
  input  logic [7:0]                 rast_fb_din,
  input  logic                       rast_zb_we,
  input  logic                       rast_zb_en,
  input  logic [gpu_pkg::ADDR_W-1:0] rast_zb_addr,
  input  logic [7:0]                 rast_zb_din,
  output logic                       fb_we,
  output logic [gpu_pkg::ADDR_W-1:0] fb_addr,
  output logic [7:0]                 fb_din,
  output logic                       zb_we,
  output logic                       zb_en,
  output logic [gpu_pkg::ADDR_W-1:0] zb_addr,
  output logic [7:0]                 zb_din,
  output logic                       timeout_err
);

  import gpu_pkg::*;

  seq_state_t state, state_next;

  logic              pending;       // frame_end seen while a triangle is busy
  logic              timeout_hit;
  logic              clr_start;
  logic              clr_done;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [7:0]        clr_fb_data;
  logic [7:0]        clr_zb_data;

  assign clr_start = (state == ST_IDLE) && frame_start;

  clear_engine #(
    .NUM_WORDS (FB_WORDS)
  ) u_clear (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (clr_start),
    .color   (clear_color),
    .done    (clr_done),
    .we      (clr_we),
    .addr    (clr_addr),
    .fb_data (clr_fb_data),
    .zb_data (clr_zb_data)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (frame_start) state_next = ST_CLEAR;
      ST_CLEAR:     if (clr_done)    state_next = ST_ACCEPT;
      ST_ACCEPT: begin
        // A triangle offered together with frame_end is served first;
        // the frame_end is remembered in pending.
        if (tri_valid)                   state_next = ST_DISPATCH;
        else if (frame_end || pending)   state_next = ST_SWAP;
      end
      ST_DISPATCH:  state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (rast_done || timeout_hit)
          state_next = (pending || frame_end) ? ST_SWAP : ST_ACCEPT;
      end
      ST_SWAP:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic, including the buffer-port mux
  // --------------------------------------------------------------------------
  always_comb begin
    tri_ready  = (state == ST_ACCEPT) && tri_valid;
    rast_start = (state == ST_DISPATCH);
    frame_done = (state == ST_SWAP);
    busy       = (state != ST_IDLE);

    if (state == ST_CLEAR) begin
      // Clear engine owns both ports; rasterizer requests are dropped
      fb_we   = clr_we;
      fb_addr = clr_addr;
      fb_din  = clr_fb_data;
      zb_we   = clr_we;
      zb_en   = clr_we;
      zb_addr = clr_addr;
      zb_din  = clr_zb_data;
    end else begin
      fb_we   = rast_fb_we;
      fb_addr = rast_fb_addr;
      fb_din  = rast_fb_din;
      zb_we   = rast_zb_we;
      zb_en   = rast_zb_en;
      zb_addr = rast_zb_addr;
      zb_din  = rast_zb_din;
    end
  end

  // --------------------------------------------------------------------------
  // Frame bookkeeping: pending close, triangle counter, front buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      tri_count <= '0;
      buf_sel   <= 1'b0;
    end else begin
      if (state == ST_SWAP)
        pending <= 1'b0;
      else if (((state == ST_ACCEPT) && tri_valid && frame_end) ||
               ((state == ST_WAIT_DONE) && frame_end))
        pending <= 1'b1;

      if (state == ST_CLEAR)
        tri_count <= '0;
      else if ((state == ST_DISPATCH) && (tri_count != 16'hFFFF))
        tri_count <= tri_count + 16'd1;

      if (state == ST_SWAP)
        buf_sel <= ~buf_sel;
    end
  end

  // --------------------------------------------------------------------------
  // Rasterizer watchdog
  // --------------------------------------------------------------------------
`ifdef RASTER_TIMEOUT_EN
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wd_cnt;

  // Fires on the TIMEOUT_CYCLES-th cycle spent waiting for rast_done
  assign timeout_hit = (state == ST_WAIT_DONE) && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_WAIT_DONE) wd_cnt <= wd_cnt + 32'd1;
      else                       wd_cnt <= '0;
      if (timeout_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;

  // TIMEOUT_CYCLES only sizes the watchdog; it is referenced here so that
  // both builds accept the same parameter set.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_render_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_render_sequencer
//  Description : Self-checking bench for render_sequencer (FB_WORDS=16,
//                TIMEOUT_CYCLES=50). A frame-level reference model predicts
//                every output on every cycle; directed frames add literal
//                expectations for clear length, handshakes, swap timing and
//                reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_render_sequencer;

  localparam int FB = 16;
  localparam int TO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 0, tri_valid = 0, frame_end = 0, rast_done = 0;
  logic [7:0]  clear_color = 0;
  logic        rast_fb_we = 0, rast_zb_we = 0, rast_zb_en = 0;
  logic [16:0] rast_fb_addr = 0, rast_zb_addr = 0;
  logic [7:0]  rast_fb_din = 0, rast_zb_din = 0;
  logic        tri_ready, frame_done, buf_sel, busy, rast_start;
  logic [15:0] tri_count;
  logic        fb_we, zb_we, zb_en, timeout_err;
  logic [16:0] fb_addr, zb_addr;
  logic [7:0]  fb_din, zb_din;

  render_sequencer #(.FB_WORDS(FB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .clear_color(clear_color),
    .tri_valid(tri_valid), .tri_ready(tri_ready), .frame_end(frame_end),
    .frame_done(frame_done), .buf_sel(buf_sel), .busy(busy), .tri_count(tri_count),
    .rast_start(rast_start), .rast_done(rast_done),
    .rast_fb_we(rast_fb_we), .rast_fb_addr(rast_fb_addr), .rast_fb_din(rast_fb_din),
    .rast_zb_we(rast_zb_we), .rast_zb_en(rast_zb_en), .rast_zb_addr(rast_zb_addr),
    .rast_zb_din(rast_zb_din),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_din(fb_din),
    .zb_we(zb_we), .zb_en(zb_en), .zb_addr(zb_addr), .zb_din(zb_din),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit noise = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Rasterizer memory traffic; Z data is never FF so clear writes stand out
  always @(posedge clk) begin
    #1;
    if (noise) begin
      rast_fb_we   = cyc[0];
      rast_fb_addr = 17'(cyc * 5);
      rast_fb_din  = 8'(cyc);
      rast_zb_we   = cyc[1];
      rast_zb_en   = 1'b1;
      rast_zb_addr = 17'(cyc * 7);
      rast_zb_din  = 8'h00;
    end else begin
      rast_fb_we = 0; rast_fb_addr = 0; rast_fb_din = 0;
      rast_zb_we = 0; rast_zb_en = 0; rast_zb_addr = 0; rast_zb_din = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: frame activity described by what is in progress
  //   m_clr  : index of the word being cleared, -1 when no clear is running
  //   m_open : frame open and waiting for a triangle or frame_end
  //   m_fly  : 0 no triangle, 1 being launched, 2 rasterizer working
  //   m_swap : buffer swap happening this cycle
  // ---------------------------------------------------------------------------
  int          m_clr = -1;
  bit          m_open = 0, m_swap = 0, m_pend = 0, m_buf = 0, m_terr = 0;
  int          m_fly = 0;
  int          m_wait = 0;
  logic [15:0] m_count = 0;
  logic [7:0]  m_color = 0;

`ifdef RASTER_TIMEOUT_EN
  wire m_to_hit = (m_fly == 2) && (m_wait + 1 == TO);
`else
  wire m_to_hit = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_clr <= -1; m_open <= 0; m_swap <= 0; m_pend <= 0; m_buf <= 0;
      m_terr <= 0; m_fly <= 0; m_wait <= 0; m_count <= 0;
    end else if (m_swap) begin
      m_swap <= 0; m_buf <= ~m_buf; m_pend <= 0;
    end else if (m_clr >= 0) begin
      m_count <= 0;
      if (m_clr == FB - 1) begin m_clr <= -1; m_open <= 1; end
      else m_clr <= m_clr + 1;
    end else if (m_fly == 1) begin
      m_fly <= 2; m_wait <= 0;
      m_count <= (m_count == 16'hFFFF) ? m_count : m_count + 16'd1;
    end else if (m_fly == 2) begin
      if (m_to_hit) m_terr <= 1;
      if (rast_done || m_to_hit) begin
        m_fly <= 0;
        if (m_pend || frame_end) m_swap <= 1;
        else m_open <= 1;
      end else begin
        if (frame_end) m_pend <= 1;
        m_wait <= m_wait + 1;
      end
    end else if (m_open) begin
      if (tri_valid) begin
        m_open <= 0; m_fly <= 1;
        if (frame_end) m_pend <= 1;
      end else if (frame_end || m_pend) begin
        m_open <= 0; m_swap <= 1;
      end
    end else if (frame_start) begin
      m_clr <= 0; m_color <= clear_color;
    end
  end

  wire        e_clr  = (m_clr >= 0);
  wire        e_idle = !e_clr && !m_open && (m_fly == 0) && !m_swap;
  wire [16:0] e_caddr = 17'(m_clr);

  // Observation counters (written only here)
  int n_clr_wr = 0, n_clr_sum = 0, n_clr_col = 0, n_tr = 0, n_rs = 0, n_fd = 0;

  always @(negedge clk) begin
    chk("busy",        busy,        !e_idle);
    chk("tri_ready",   tri_ready,   m_open && tri_valid);
    chk("rast_start",  rast_start,  m_fly == 1);
    chk("frame_done",  frame_done,  m_swap);
    chk("buf_sel",     buf_sel,     m_buf);
    chk("tri_count",   tri_count,   m_count);
    chk("timeout_err", timeout_err, m_terr);
    chk("fb_we",   fb_we,   e_clr ? 1'b1    : rast_fb_we);
    chk("fb_addr", fb_addr, e_clr ? e_caddr : rast_fb_addr);
    chk("fb_din",  fb_din,  e_clr ? m_color : rast_fb_din);
    chk("zb_we",   zb_we,   e_clr ? 1'b1    : rast_zb_we);
    chk("zb_en",   zb_en,   e_clr ? 1'b1    : rast_zb_en);
    chk("zb_addr", zb_addr, e_clr ? e_caddr : rast_zb_addr);
    chk("zb_din",  zb_din,  e_clr ? 8'hFF   : rast_zb_din);
    if (zb_we && zb_din == 8'hFF) begin
      n_clr_wr++;
      n_clr_sum += int'(fb_addr);
      if (fb_din == 8'h3C) n_clr_col++;
    end
    if (tri_ready)  n_tr++;
    if (rast_start) n_rs++;
    if (frame_done) n_fd++;
  end

  int s_wr, s_sum, s_col, s_tr, s_rs, s_fd;

  initial begin
    // ---------------- reset ----------------
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_buf_sel", buf_sel, 0);
    chk("rst_tri_count", tri_count, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_zb_en", zb_en, 0);
    chk("rst_tri_ready", tri_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    #1 rst_n = 1;

    // ---------------- IDLE ignores triangles, frame_end, rast_done ----------
    s_tr = n_tr;
    tick(); tri_valid = 1; frame_end = 1; rast_done = 1;
    repeat (3) tick();
    tri_valid = 0; frame_end = 0; rast_done = 0;
    #1;
    chk("idle_tri_ready_cnt", n_tr - s_tr, 0);
    chk("idle_busy", busy, 0);

    // ---------------- frame 1: clear, two triangles, close in WAIT_DONE -----
    noise = 1;
    s_wr = n_clr_wr; s_sum = n_clr_sum; s_col = n_clr_col; s_rs = n_rs; s_fd = n_fd;
    clear_color = 8'h3C; frame_start = 1;
    tick();                                   // cycle 1: address 0
    frame_start = 0; clear_color = 8'h55;
    for (int i = 1; i <= 15; i++) begin       // ends in cycle 16
      tick();
      frame_start = (i == 4);                 // ignored mid-clear
    end
    frame_start = 0; tri_valid = 1;
    #1;
    chk("c16_fb_addr", fb_addr, 15);
    chk("c16_tri_ready", tri_ready, 0);
    tick();                                   // cycle 17: ACCEPT
    #1;
    chk("c17_tri_ready", tri_ready, 1);
    chk("clr_writes", n_clr_wr - s_wr, 16);
    chk("clr_addr_sum", n_clr_sum - s_sum, 120);
    chk("clr_color_hits", n_clr_col - s_col, 16);
    tick();                                   // cycle 18: DISPATCH
    #1;
    chk("t1_rast_start", rast_start, 1);
    s_tr = n_tr;
    repeat (20) tick();                       // cycle 38
    rast_done = 1;
    #1;
    chk("wait_tri_ready_cnt", n_tr - s_tr, 0);
    chk("t1_tri_count", tri_count, 1);
    tick();                                   // cycle 39: ACCEPT again
    rast_done = 0;
    #1;
    chk("t2_tri_ready", tri_ready, 1);
    tick();                                   // cycle 40: DISPATCH
    tri_valid = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      frame_end = (i == 5);
    end
    frame_end = 0; rast_done = 1;             // cycle 60
    #1;
    chk("f1_done_early", frame_done, 0);
    tick();                                   // cycle 61: SWAP
    rast_done = 0;
    #1;
    chk("f1_frame_done", frame_done, 1);
    tick();
    #1;
    chk("f1_buf_sel", buf_sel, 1);
    chk("f1_tri_count", tri_count, 2);
    chk("f1_busy", busy, 0);
    chk("f1_starts", n_rs - s_rs, 2);
    chk("f1_done_pulses", n_fd - s_fd, 1);

    // ---------------- frame 2: triangle and frame_end together -------------
    clear_color = 8'hA5; frame_start = 1;
    tick(); frame_start = 0;
    repeat (16) tick();                       // cycle 17: ACCEPT
    tri_valid = 1; frame_end = 1;
    #1;
    chk("f2_tri_ready", tri_ready, 1);
    tick();                                   // cycle 18: DISPATCH
    tri_valid = 0; frame_end = 0;
    #1;
    chk("f2_rast_start", rast_start, 1);
    chk("f2_no_early_swap", frame_done, 0);
    repeat (20) tick();                       // cycle 38
    rast_done = 1;
    tick();                                   // cycle 39: SWAP
    rast_done = 0;
    #1;
    chk("f2_frame_done", frame_done, 1);
    tick();
    #1;
    chk("f2_buf_sel", buf_sel, 0);
    chk("f2_tri_count", tri_count, 1);

    // ---------------- frame 3: reset during clear ---------------------------
    noise = 0;
    tick();
    clear_color = 8'h11; frame_start = 1;
    tick(); frame_start = 0;                  // cycle 1: address 0
    repeat (7) tick();                        // cycle 8: address 7
    #1;
    chk("f3_addr7", fb_addr, 7);
    #1 rst_n = 0;
    #1;
    chk("f3_rst_busy", busy, 0);
    chk("f3_rst_fb_we", fb_we, 0);
    chk("f3_rst_zb_we", zb_we, 0);
    chk("f3_rst_zb_en", zb_en, 0);
    chk("f3_rst_tri_count", tri_count, 0);
    @(negedge clk); #2 rst_n = 1;
    s_wr = n_clr_wr;
    repeat (10) tick();
    chk("f3_no_writes", n_clr_wr - s_wr, 0);
    chk("f3_idle", busy, 0);

    // ---------------- frame 4: rasterizer never answers --------------------
    clear_color = 8'h22; frame_start = 1;
    tick(); frame_start = 0;
    repeat (16) tick();                       // cycle 17
    tri_valid = 1;
    tick(); tri_valid = 0;                    // cycle 18: DISPATCH
    repeat (50) tick();                       // cycle 68
    #1;
    chk("f4_err_before", timeout_err, 0);
    tick();                                   // cycle 69
`ifdef RASTER_TIMEOUT_EN
    #1;
    chk("f4_timeout_err", timeout_err, 1);
    frame_end = 1;
    tick(); frame_end = 0;                    // cycle 70
    #1;
    chk("f4_frame_done", frame_done, 1);
`else
    #1;
    chk("f4_no_timeout", timeout_err, 0);
    chk("f4_still_busy", busy, 1);
    frame_end = 1;
    tick(); frame_end = 0;                    // cycle 70
    #1;
    chk("f4_no_swap", frame_done, 0);
    repeat (10) tick();                       // cycle 80
    rast_done = 1;
    tick(); rast_done = 0;                    // cycle 81
    #1;
    chk("f4_frame_done", frame_done, 1);
`endif
    repeat (3) tick();
    chk("f4_buf_sel", buf_sel, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
